// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control sequencer.
// Contents: state codes, ALU/CMP operation codes, opcode/funct values and mux encodings.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      IC_ADDU,
      IC_SUBU,
      IC_ORI,
      IC_LUI,
      IC_LW,
      IC_SW,
      IC_BEQ,
      IC_JAL,
      IC_JR,
      IC_ILLEGAL
   } instr_class_e;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_LUI  = 4'd3;

   localparam logic [3:0] CMP_NONE = 4'd0;
   localparam logic [3:0] CMP_BEQ  = 4'd1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_ZEXT = 2'd1;
   localparam logic [1:0] SRCB_SEXT = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MDR    = 2'd1;
   localparam logic [1:0] WD_PC     = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath/memories (slave).
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       branch;
   logic       imem_ready;
   logic       dmem_ready;

   logic       imem_req;
   logic       dmem_req;
   logic       dmem_we;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       ab_we;
   logic [3:0] alu_op;
   logic [1:0] alu_src_b;
   logic [3:0] cmp_op;
   logic       aluout_we;
   logic       mdr_we;
   logic       reg_we;
   logic [1:0] reg_dst;
   logic [1:0] wd_sel;
   logic [2:0] state;
   logic       retire;
   logic       illegal_instr;
   logic       mem_timeout;

   modport master (
      input  opcode, funct, branch, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, ab_we,
             alu_op, alu_src_b, cmp_op, aluout_we, mdr_we, reg_we,
             reg_dst, wd_sel, state, retire, illegal_instr, mem_timeout
   );

   modport slave (
      output opcode, funct, branch, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, ab_we,
             alu_op, alu_src_b, cmp_op, aluout_we, mdr_we, reg_we,
             reg_dst, wd_sel, state, retire, illegal_instr, mem_timeout
   );

endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational opcode/funct classifier; the all-zero nop falls out as addu.
module multicycle_ctrl_instr_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_e cls,
   output logic         illegal
);

   always_comb begin
      cls = IC_ILLEGAL;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (funct)
               FN_ADDU, FN_NOP: cls = IC_ADDU;
               FN_SUBU:         cls = IC_SUBU;
               FN_JR:           cls = IC_JR;
               default:         cls = IC_ILLEGAL;
            endcase
         end
         OP_ORI:  cls = IC_ORI;
         OP_LUI:  cls = IC_LUI;
         OP_LW:   cls = IC_LW;
         OP_SW:   cls = IC_SW;
         OP_BEQ:  cls = IC_BEQ;
         OP_JAL:  cls = IC_JAL;
         default: cls = IC_ILLEGAL;
      endcase
      illegal = (cls == IC_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS core.
// Only the state and wait counter are registered; every control output is decoded from them.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 16,
   parameter int unsigned WAIT_W       = 5
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);

   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_WAIT_MAX == 0) ? '0 : WAIT_W'(MEM_WAIT_MAX - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;

   instr_class_e cls;
   logic         illegal;
   logic         wait_expired;

   logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, ab_we_c;
   logic       aluout_we_c, mdr_we_c, reg_we_c, retire_c, illegal_c, timeout_c;
   logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, wd_sel_c;
   logic [3:0] alu_op_c, cmp_op_c;

   multicycle_ctrl_instr_decode u_decode (
      .opcode  (bus.opcode),
      .funct   (bus.funct),
      .cls     (cls),
      .illegal (illegal)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      wait_expired = (MEM_WAIT_MAX != 0) && (cnt_q == WAIT_LAST);
      imem_req_c   = 1'b0;
      dmem_req_c   = 1'b0;
      dmem_we_c    = 1'b0;
      ir_we_c      = 1'b0;
      pc_we_c      = 1'b0;
      pc_src_c     = PC_SRC_SEQ;
      ab_we_c      = 1'b0;
      alu_op_c     = ALU_ADD;
      alu_src_b_c  = SRCB_REG;
      cmp_op_c     = CMP_NONE;
      aluout_we_c  = 1'b0;
      mdr_we_c     = 1'b0;
      reg_we_c     = 1'b0;
      reg_dst_c    = DST_RT;
      wd_sel_c     = WD_ALUOUT;
      retire_c     = 1'b0;
      illegal_c    = 1'b0;
      timeout_c    = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ready) begin
               ir_we_c  = 1'b1;
               pc_we_c  = 1'b1;
               pc_src_c = PC_SRC_SEQ;
               state_d  = ST_DECODE;
            end else if (wait_expired) begin
               // PC is left alone so the next FETCH retries the same word.
               timeout_c = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DECODE: begin
            state_d = ST_FETCH;
            if (illegal) begin
               illegal_c = 1'b1;
            end else begin
               ab_we_c = 1'b1;
               unique case (cls)
                  IC_JAL: begin
                     reg_we_c  = 1'b1;
                     reg_dst_c = DST_RA;
                     wd_sel_c  = WD_PC;
                     pc_we_c   = 1'b1;
                     pc_src_c  = PC_SRC_JUMP;
                     retire_c  = 1'b1;
                  end
                  IC_JR: begin
                     pc_we_c  = 1'b1;
                     pc_src_c = PC_SRC_RS;
                     retire_c = 1'b1;
                  end
                  default: state_d = ST_EXEC;
               endcase
            end
         end

         ST_EXEC: begin
            aluout_we_c = 1'b1;
            state_d     = ST_WB;
            unique case (cls)
               IC_ADDU: alu_op_c = ALU_ADD;
               IC_SUBU: alu_op_c = ALU_SUB;
               IC_ORI: begin
                  alu_op_c    = ALU_OR;
                  alu_src_b_c = SRCB_ZEXT;
               end
               IC_LUI: begin
                  alu_op_c    = ALU_LUI;
                  alu_src_b_c = SRCB_ZEXT;
               end
               IC_LW, IC_SW: begin
                  alu_op_c    = ALU_ADD;
                  alu_src_b_c = SRCB_SEXT;
                  state_d     = ST_MEM;
               end
               IC_BEQ: begin
                  aluout_we_c = 1'b0;
                  alu_op_c    = ALU_SUB;
                  cmp_op_c    = CMP_BEQ;
                  pc_we_c     = bus.branch;
                  pc_src_c    = bus.branch ? PC_SRC_BRANCH : PC_SRC_SEQ;
                  retire_c    = 1'b1;
                  state_d     = ST_FETCH;
               end
               default: begin
                  aluout_we_c = 1'b0;
                  state_d     = ST_FETCH;
               end
            endcase
         end

         ST_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (cls == IC_SW);
            if (bus.dmem_ready) begin
               if (cls == IC_SW) begin
                  retire_c = 1'b1;
                  state_d  = ST_FETCH;
               end else begin
                  mdr_we_c = 1'b1;
                  state_d  = ST_WB;
               end
            end else if (wait_expired) begin
               dmem_req_c = 1'b0;
               dmem_we_c  = 1'b0;
               timeout_c  = 1'b1;
               state_d    = ST_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_WB: begin
            reg_we_c = 1'b1;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
            unique case (cls)
               IC_ADDU, IC_SUBU: reg_dst_c = DST_RD;
               IC_LW:            wd_sel_c  = WD_MDR;
               default:          reg_dst_c = DST_RT;
            endcase
         end

         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by reset so an asserted reset silences every strobe immediately.
   assign bus.imem_req      = reset & imem_req_c;
   assign bus.dmem_req      = reset & dmem_req_c;
   assign bus.dmem_we       = reset & dmem_we_c;
   assign bus.ir_we         = reset & ir_we_c;
   assign bus.pc_we         = reset & pc_we_c;
   assign bus.pc_src        = reset ? pc_src_c    : '0;
   assign bus.ab_we         = reset & ab_we_c;
   assign bus.alu_op        = reset ? alu_op_c    : '0;
   assign bus.alu_src_b     = reset ? alu_src_b_c : '0;
   assign bus.cmp_op        = reset ? cmp_op_c    : '0;
   assign bus.aluout_we     = reset & aluout_we_c;
   assign bus.mdr_we        = reset & mdr_we_c;
   assign bus.reg_we        = reset & reg_we_c;
   assign bus.reg_dst       = reset ? reg_dst_c   : '0;
   assign bus.wd_sel        = reset ? wd_sel_c    : '0;
   assign bus.state         = reset ? state_q     : '0;
   assign bus.retire        = reset & retire_c;
   assign bus.illegal_instr = reset & illegal_c;
   assign bus.mem_timeout   = reset & timeout_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_WAIT_MAX=16).
module tb_multicycle_ctrl;

   logic clk;
   logic reset;
   int   pass_cnt;
   int   chk_cnt;
   logic [31:0] got;
   logic [31:0] exp;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(
      .MEM_WAIT_MAX (16),
      .WAIT_W       (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.imem_ready = 1'b1;
      tick();
      tick();
      got = {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.retire};
      exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL reset_outputs got=%h exp=%h", got, exp); else pass_cnt++;
      bus.imem_ready = 1'b0;
      reset = 1'b1;
      #1;
      got = {bus.state, bus.imem_req, bus.ir_we};
      exp = {3'd0, 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL reset_release got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_addu();
      bus.opcode = 6'h00; bus.funct = 6'h21;
      bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.branch = 1'b0;
      #1;
      got = {bus.state, bus.ir_we, bus.pc_we, bus.pc_src};
      exp = {3'd0, 1'b1, 1'b1, 2'd0};
      chk_cnt++;
      if (got !== exp) $display("FAIL addu_fetch got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.ab_we, bus.reg_we, bus.retire};
      exp = {3'd1, 1'b1, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL addu_decode got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.alu_op, bus.alu_src_b, bus.aluout_we, bus.reg_we};
      exp = {3'd2, 4'd0, 2'd0, 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL addu_exec got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.retire};
      exp = {3'd4, 1'b1, 2'd1, 2'd0, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL addu_wb got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.retire};
      exp = {3'd0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL addu_done got=%h exp=%h", got, exp); else pass_cnt++;
   endtask

   task automatic test_ori();
      bus.opcode = 6'h0d; bus.funct = 6'h3f;
      bus.imem_ready = 1'b1;
      tick();
      tick();
      got = {bus.state, bus.alu_op, bus.alu_src_b, bus.aluout_we};
      exp = {3'd2, 4'd2, 2'd1, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL ori_exec got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.retire};
      exp = {3'd4, 1'b1, 2'd0, 2'd0, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL ori_wb got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_sw();
      bus.opcode = 6'h2b;
      bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
      tick();
      tick();
      got = {bus.state, bus.alu_op, bus.alu_src_b, bus.aluout_we};
      exp = {3'd2, 4'd0, 2'd2, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL sw_exec got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.dmem_req, bus.dmem_we, bus.retire, bus.mdr_we, bus.reg_we};
      exp = {3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL sw_mem got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {29'd0, bus.state};
      exp = 32'd0;
      chk_cnt++;
      if (got !== exp) $display("FAIL sw_done got=%h exp=%h", got, exp); else pass_cnt++;
   endtask

   task automatic test_lw_wait();
      bus.opcode = 6'h23;
      bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
      tick();
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         got = {bus.state, bus.dmem_req, bus.dmem_we, bus.mdr_we, bus.mem_timeout};
         exp = {3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
         chk_cnt++;
         if (got !== exp) $display("FAIL lw_mem_wait%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
         tick();
      end
      bus.dmem_ready = 1'b1;
      #1;
      got = {bus.state, bus.dmem_req, bus.mdr_we};
      exp = {3'd3, 1'b1, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL lw_mem_ready got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.retire, bus.mdr_we};
      exp = {3'd4, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL lw_wb got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_beq(input logic br);
      bus.opcode = 6'h04; bus.branch = 1'b0;
      bus.imem_ready = 1'b1;
      tick();
      tick();
      bus.branch = br;
      #1;
      got = {bus.state, bus.alu_op, bus.cmp_op, bus.pc_we, bus.pc_src, bus.retire, bus.aluout_we};
      exp = {3'd2, 4'd1, 4'd1, br, (br ? 2'd1 : 2'd0), 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL beq_exec_br%0b got=%h exp=%h", br, got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.retire};
      exp = {3'd0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL beq_done_br%0b got=%h exp=%h", br, got, exp); else pass_cnt++;
      bus.branch = 1'b0;
   endtask

   task automatic test_jal();
      bus.opcode = 6'h03;
      bus.imem_ready = 1'b1;
      tick();
      got = {bus.state, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.pc_we, bus.pc_src, bus.retire};
      exp = {3'd1, 1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL jal_decode got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.reg_we};
      exp = {3'd0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL jal_next got=%h exp=%h", got, exp); else pass_cnt++;
   endtask

   task automatic test_fetch_timeout();
      bus.imem_ready = 1'b0;
      #1;
      for (int i = 0; i < 15; i++) begin
         got = {bus.state, bus.mem_timeout, bus.pc_we, bus.ir_we};
         exp = {3'd0, 1'b0, 1'b0, 1'b0};
         chk_cnt++;
         if (got !== exp) $display("FAIL fetch_wait%0d got=%h exp=%h", i, got, exp); else pass_cnt++;
         tick();
      end
      got = {bus.state, bus.mem_timeout, bus.pc_we, bus.ir_we};
      exp = {3'd0, 1'b1, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL fetch_timeout got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.mem_timeout, bus.pc_we};
      exp = {3'd0, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL fetch_after_timeout got=%h exp=%h", got, exp); else pass_cnt++;
   endtask

   task automatic test_ready_wins();
      bus.opcode = 6'h00; bus.funct = 6'h08;
      bus.imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      bus.imem_ready = 1'b1;
      #1;
      got = {bus.state, bus.mem_timeout, bus.ir_we, bus.pc_we};
      exp = {3'd0, 1'b0, 1'b1, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL ready_wins got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.pc_we, bus.pc_src, bus.retire, bus.reg_we};
      exp = {3'd1, 1'b1, 2'd3, 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL jr_decode got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_lw();
      bus.opcode = 6'h23;
      bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
      tick();
      tick();
      tick();
      got = {bus.state, bus.dmem_req};
      exp = {3'd3, 1'b1};
      chk_cnt++;
      if (got !== exp) $display("FAIL rst_lw_in_mem got=%h exp=%h", got, exp); else pass_cnt++;
      reset = 1'b0;
      bus.dmem_ready = 1'b1;
      #1;
      got = {bus.state, bus.dmem_req, bus.dmem_we, bus.mdr_we, bus.reg_we,
             bus.imem_req, bus.ab_we, bus.retire, bus.wd_sel, bus.alu_src_b};
      exp = 32'd0;
      chk_cnt++;
      if (got !== exp) $display("FAIL rst_mid_outputs got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      bus.opcode = 6'h3f;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
      reset = 1'b1;
      #1;
      got = {bus.state, bus.imem_req, bus.ir_we};
      exp = {3'd0, 1'b1, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL rst_release_fetch got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {29'd0, bus.state};
      exp = 32'd0;
      chk_cnt++;
      if (got !== exp) $display("FAIL rst_hold_fetch got=%h exp=%h", got, exp); else pass_cnt++;
      bus.imem_ready = 1'b1;
      tick();
      got = {bus.state, bus.illegal_instr, bus.reg_we, bus.pc_we, bus.retire};
      exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL illegal_decode got=%h exp=%h", got, exp); else pass_cnt++;
      tick();
      got = {bus.state, bus.illegal_instr};
      exp = {3'd0, 1'b0};
      chk_cnt++;
      if (got !== exp) $display("FAIL illegal_next got=%h exp=%h", got, exp); else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", chk_cnt);
      $fatal(1);
   end

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      reset = 1'b0;
      bus.opcode = '0; bus.funct = '0; bus.branch = 1'b0;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
      test_reset();
      test_addu();
      test_ori();
      test_sw();
      test_lw_wait();
      test_beq(1'b1);
      test_beq(1'b0);
      test_jal();
      test_fetch_timeout();
      test_ready_wins();
      test_reset_mid_lw();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the MIPS core. Runs one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. Drives the ALU operation and compare select, the datapath register write-enables and the mux selects, and the instruction-memory and data-memory request handshakes. It replaces the single-cycle combinational controller, so the one ALU/CMP unit is reused for every phase of an instruction.

Parameters:
MEM_WAIT_MAX, 16, maximum number of cycles spent waiting for a memory ready before the access is abandon­ed; 0 disables the timeout.
WAIT_W, 5, width of the wait counter; must satisfy 2^WAIT_W > MEM_WAIT_MAX.

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
branch  in  1  Branch output of the ALU compare
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write (sw)
ir_we  out  1  latch IR
pc_we  out  1  update PC
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs
ab_we  out  1  latch A/B operand registers
alu_op  out  4  ADD/SUB/OR/LUI encoding
alu_src_b  out  2  0=B reg, 1=zero-ext imm, 2=sign-ext imm
cmp_op  out  4  CMPOp_beq or none
aluout_we  out  1  latch ALUOut
mdr_we  out  1  latch memory data register
reg_we  out  1  register-file write
reg_dst  out  2  0=rt, 1=rd, 2=$31
wd_sel  out  2  0=ALUOut, 1=MDR, 2=PC (link)
state  out  3  current state, for debug
retire  out  1  one-cycle pulse on the final cycle of a legal instruction
illegal_instr  out  1  one-cycle pulse on an unsupported encoding
mem_timeout  out  1  one-cycle pulse when a memory wait is abandoned

Behaviour:
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, jal, jr. Everything else is illegal, except nop (all zeros), which is treated as addu $0.
- State register and wait counter are the only flops. All outputs are combinational from state, opcode, funct, branch and the ready inputs.
- While reset=0: state=FETCH, counter=0, and every output is forced to 0; state reads 0 = FETCH.
- FETCH: imem_req=1. On imem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise stay and increment the counter.
- DECODE: ab_we=1.
  - jal: reg_we=1, reg_dst=2, wd_sel=2, pc_we=1, pc_src=2, retire, then FETCH.
  - jr: pc_we=1, pc_src=3, retire, then FETCH.
  - Illegal: illegal_instr=1, no write strobes, then FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - addu: alu_op=ADD, src_b=0. subu: SUB, src_b=0. ori: OR, src_b=1. lui: LUI, src_b=1. For all four, aluout_we=1, then WB.
  - lw/sw: ADD, src_b=2, aluout_we=1, then MEM.
  - beq: alu_op=SUB, cmp_op=beq. If branch=1, pc_we=1 and pc_src=1. Then retire and go to FETCH.
- MEM: dmem_req=1, dmem_we=(sw). On dmem_ready: sw retires and goes to FETCH; lw asserts mdr_we=1 and goes to WB. Otherwise increment the counter.
- WB: reg_we=1.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
  - retire, then FETCH.
- Latency with zero wait states: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal/jr 2.
- Timeout: the counter clears on every state change. If the counter equals MEM_WAIT_MAX-1 and ready is still 0, pulse mem_timeout, go to FETCH, and assert no write strobes; the PC is not advanced, so the fetch is retried. If ready=1 in that same cycle, ready wins and there is no timeout.
- Reset asserted mid-instruction: the instruction is abandoned immediately, with no partial reg_we/dmem_we. After reset deassertion, the first active edge leaves FETCH only if imem_ready=1.

Decomposition:
- The shared const package holds ALUOp codes ADD=0, SUB=1, OR=2, LUI=3 and CMPOp_beq=1 (none=0).
- It also holds the opcode/funct constants (R=0x00, ori=0x0d, lui=0x0f, lw=0x23, sw=0x2b, beq=0x04, jal=0x03, addu=0x21, subu=0x23, jr=0x08) and the state codes FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- One natural sub-module is instr_decode: purely combinational, mapping opcode/funct to an instruction class and illegal flag. The FSM stays in multicycle_ctrl.

Test Plan:
- addu (op 0x00, funct 0x21), ready tied 1 → states 0,1,2,4. alu_op=0 in EXEC; reg_we=1, reg_dst=1 in WB; retire in cycle 4.
- lw (0x23), dmem_ready low for 3 cycles → MEM held 4 cycles, mdr_we only in the ready cycle. WB has wd_sel=1, reg_dst=0; 8 cycles total.
- beq (0x04) with branch=1, then with branch=0 → pc_we=1, pc_src=1 only in the first case. Both retire in 3 cycles.
- jal (0x03) → in DECODE: reg_we=1, reg_dst=2, wd_sel=2, pc_src=2; next state FETCH.
- imem_ready held 0 with MEM_WAIT_MAX=16 → mem_timeout pulses in the 16th FETCH cycle, pc_we never asserted. Repeat with ready=1 in that cycle: no timeout.
- reset→0 during the lw MEM state → all outputs 0 at once, state=0. Release with opcode 0x3f (illegal) → illegal_instr pulses in DECODE, no reg_we.
